// File: rtl/rob_commit_unit_pkg.sv
// Shared RS/ROB types: row count, field widths, ROB entry layout and index type.
// rob_entry_t grows an exc bit when ROB_EXCEPTION_EN is defined.
package rob_commit_unit_pkg;
  localparam int ROB_ROW_COUNT = 64;
  localparam int ROB_DEPTH     = ROB_ROW_COUNT;
  localparam int IDX_W         = $clog2(ROB_DEPTH);
  localparam int PREG_W        = 6;
  localparam int PC_W          = 32;
  localparam int NUM_CMPL      = 2;

  typedef logic [IDX_W-1:0]  rob_idx_t;
  typedef logic [IDX_W:0]    rob_cnt_t;
  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [PC_W-1:0]   pc_t;

  typedef struct packed {
    logic  used;
    preg_t destreg;
    preg_t old_destreg;
    pc_t   pc;
    logic  completed;
`ifdef ROB_EXCEPTION_EN
    logic  exc;
`endif
  } rob_entry_t;

  // Port 0 sits in the LSBs of the packed completion index bus.
  function automatic rob_idx_t cmpl_idx(input logic [NUM_CMPL*IDX_W-1:0] bus, input int port);
    return bus[port*IDX_W +: IDX_W];
  endfunction
endpackage

// File: rtl/rob_commit_unit_if.sv
// Dispatch/completion/retire bundle of the ROB; master = core side, slave = ROB.
// ROB_EXCEPTION_EN adds cmpl_exc, exc_valid and exc_pc.
interface rob_commit_unit_if;
  import rob_commit_unit_pkg::*;

  logic                      alloc_valid;
  logic                      alloc_ready;
  preg_t                     alloc_destreg;
  preg_t                     alloc_old_destreg;
  pc_t                       alloc_pc;
  rob_idx_t                  alloc_rob_idx;
  logic [NUM_CMPL-1:0]       cmpl_valid;
  logic [NUM_CMPL*IDX_W-1:0] cmpl_rob_idx;
  logic                      flush;
  logic                      retire_valid;
  rob_idx_t                  retire_rob_idx;
  preg_t                     retire_destreg;
  preg_t                     retire_old_destreg;
  pc_t                       retire_pc;
  rob_cnt_t                  count;
  logic                      empty;
  logic                      full;
`ifdef ROB_EXCEPTION_EN
  logic [NUM_CMPL-1:0]       cmpl_exc;
  logic                      exc_valid;
  pc_t                       exc_pc;
`endif

  modport master (
    output alloc_valid, alloc_destreg, alloc_old_destreg, alloc_pc,
    output cmpl_valid, cmpl_rob_idx, flush,
    input  alloc_ready, alloc_rob_idx,
    input  retire_valid, retire_rob_idx, retire_destreg, retire_old_destreg, retire_pc,
    input  count, empty, full
`ifdef ROB_EXCEPTION_EN
    , output cmpl_exc, input exc_valid, exc_pc
`endif
  );

  modport slave (
    input  alloc_valid, alloc_destreg, alloc_old_destreg, alloc_pc,
    input  cmpl_valid, cmpl_rob_idx, flush,
    output alloc_ready, alloc_rob_idx,
    output retire_valid, retire_rob_idx, retire_destreg, retire_old_destreg, retire_pc,
    output count, empty, full
`ifdef ROB_EXCEPTION_EN
    , input cmpl_exc, output exc_valid, exc_pc
`endif
  );
endinterface

// File: rtl/rob_ptr_ctrl.sv
// ROB head/tail/count bookkeeping; fire strobes are combinational from registered state.
// Allocation refused while full (no retire-to-alloc bypass); flush wins over everything.
module rob_ptr_ctrl
  import rob_commit_unit_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     alloc_req,
  input  logic     retire_req,
  input  logic     flush,
  output rob_idx_t head,
  output rob_idx_t tail,
  output rob_cnt_t count,
  output logic     full,
  output logic     empty,
  output logic     alloc_fire,
  output logic     retire_fire
);
  assign full        = (count == rob_cnt_t'(ROB_DEPTH));
  assign empty       = (count == '0);
  assign alloc_fire  = alloc_req && !full && !flush;
  assign retire_fire = retire_req && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc_fire)  tail <= tail + rob_idx_t'(1);
      if (retire_fire) head <= head + rob_idx_t'(1);
      unique case ({alloc_fire, retire_fire})
        2'b10:   count <= count + rob_cnt_t'(1);
        2'b01:   count <= count - rob_cnt_t'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/rob_commit_unit.sv
// Reorder buffer rows + in-order retire; completion at edge N retires at edge N+1 at the earliest.
// Backpressure via alloc_ready (!full); ROB_EXCEPTION_EN makes a faulting head pulse exc_valid and self-flush.
module rob_commit_unit
  import rob_commit_unit_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  rob_commit_unit_if.slave rob
);
  rob_entry_t ent_q [ROB_DEPTH];
  rob_entry_t head_ent;
  rob_idx_t   head;
  rob_idx_t   tail;
  rob_cnt_t   count;
  logic       full;
  logic       empty;
  logic       alloc_fire;
  logic       retire_fire;
  logic       retire_req;
  logic       exc_fire;
  logic       flush_all;

  assign head_ent = ent_q[head];
`ifdef ROB_EXCEPTION_EN
  assign exc_fire = head_ent.used && head_ent.completed && head_ent.exc;
`else
  assign exc_fire = 1'b0;
`endif
  assign retire_req = head_ent.used && head_ent.completed && !exc_fire;
  assign flush_all  = rob.flush || exc_fire;

  rob_ptr_ctrl u_ptr (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc_req   (rob.alloc_valid),
    .retire_req  (retire_req),
    .flush       (flush_all),
    .head        (head),
    .tail        (tail),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .alloc_fire  (alloc_fire),
    .retire_fire (retire_fire)
  );

  assign rob.alloc_ready   = !full;
  assign rob.alloc_rob_idx = tail;
  assign rob.count         = count;
  assign rob.empty         = empty;
  assign rob.full          = full;

  // Later writes win: a retiring head hit by a completion still clears, and alloc lands last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROB_DEPTH; i++) ent_q[i] <= '0;
    end else if (flush_all) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        ent_q[i].used      <= 1'b0;
        ent_q[i].completed <= 1'b0;
      end
    end else begin
      for (int p = 0; p < NUM_CMPL; p++) begin
        if (rob.cmpl_valid[p] && ent_q[cmpl_idx(rob.cmpl_rob_idx, p)].used) begin
          ent_q[cmpl_idx(rob.cmpl_rob_idx, p)].completed <= 1'b1;
`ifdef ROB_EXCEPTION_EN
          if (rob.cmpl_exc[p]) ent_q[cmpl_idx(rob.cmpl_rob_idx, p)].exc <= 1'b1;
`endif
        end
      end
      if (retire_fire) begin
        ent_q[head].used      <= 1'b0;
        ent_q[head].completed <= 1'b0;
      end
      if (alloc_fire) begin
        ent_q[tail].used        <= 1'b1;
        ent_q[tail].completed   <= 1'b0;
        ent_q[tail].destreg     <= rob.alloc_destreg;
        ent_q[tail].old_destreg <= rob.alloc_old_destreg;
        ent_q[tail].pc          <= rob.alloc_pc;
`ifdef ROB_EXCEPTION_EN
        ent_q[tail].exc         <= 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rob.retire_valid       <= 1'b0;
      rob.retire_rob_idx     <= '0;
      rob.retire_destreg     <= '0;
      rob.retire_old_destreg <= '0;
      rob.retire_pc          <= '0;
    end else begin
      rob.retire_valid <= retire_fire;
      if (retire_fire) begin
        rob.retire_rob_idx     <= head;
        rob.retire_destreg     <= head_ent.destreg;
        rob.retire_old_destreg <= head_ent.old_destreg;
        rob.retire_pc          <= head_ent.pc;
      end
    end
  end

`ifdef ROB_EXCEPTION_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rob.exc_valid <= 1'b0;
      rob.exc_pc    <= '0;
    end else begin
      rob.exc_valid <= exc_fire;
      if (exc_fire) rob.exc_pc <= head_ent.pc;
    end
  end
`endif
endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- Reorder buffer storage plus in-order retire stage of the out-of-order core.
- Downstream of rename/dispatch: each dispatched instruction is allocated here in program order, and the returned ROB index is written into that instruction's RS row.
- Functional units mark entries completed.
- The head entry retires when completed; its old physical destination is handed to the free list.

Parameters:
- ROB_DEPTH, 64, number of ROB rows (power of two)
- IDX_W, 6, log2(ROB_DEPTH)
- PREG_W, 6, physical register tag width
- PC_W, 32, program counter width
- NUM_CMPL, 2, number of completion ports

Ports:
- clk in 1: core clock
- rst_n in 1: asynchronous, active-low reset
- alloc_valid in 1: dispatch requests an allocation
- alloc_ready out 1: ROB can accept an allocation this cycle
- alloc_destreg in PREG_W: new physical destination
- alloc_old_destreg in PREG_W: previous mapping of the architectural destination
- alloc_pc in PC_W: instruction PC
- alloc_rob_idx out IDX_W: index granted (equals the tail pointer)
- cmpl_valid in NUM_CMPL: per-port completion strobe
- cmpl_rob_idx in NUM_CMPL*IDX_W: packed completion indices (port 0 in the LSBs)
- flush in 1: discard all entries
- retire_valid out 1: one-cycle pulse, entry retired
- retire_rob_idx out IDX_W: index of the retired entry
- retire_destreg out PREG_W: retired entry's destination
- retire_old_destreg out PREG_W: tag to release to the free list
- retire_pc out PC_W: retired entry's PC
- count out IDX_W+1: occupied entries
- empty out 1: count==0
- full out 1: count==ROB_DEPTH

Behaviour:
- Reset (asynchronous, rst_n=0):
  - all used and completed bits are 0; head=tail=0; count=0
  - retire_valid=0; all retire_* data outputs are 0
  - alloc_ready=1, empty=1, full=0
- Derived outputs: alloc_ready = !full, combinational from registered count. alloc_rob_idx = tail, combinational.
- Allocate: on an edge with alloc_valid && alloc_ready:
  - entry[tail] gets used=1, completed=0, destreg, old_destreg, pc
  - tail wraps mod ROB_DEPTH
- Complete: on an edge with cmpl_valid[i]:
  - if entry[idx].used, set completed=1; completing an unused entry is ignored
  - two ports hitting the same index is idempotent
  - completion of the current tail index in the same cycle as its allocation is ignored (the entry is not yet used)
- Retire:
  - retire condition at an edge = entry[head].used && entry[head].completed
  - on a retiring edge:
    - head's used and completed bits clear; head increments with wrap
    - retire_* are registered with that entry's fields; retire_valid=1 for exactly that following cycle
  - no retire when empty; at most one retire per cycle
  - latency: completion captured at edge N, earliest retire pulse after edge N+1 (no completion-to-retire bypass)
- Count update: count += alloc_fire - retire_fire, so simultaneous alloc and retire leaves count unchanged. When full, allocation is refused even in a retiring cycle (no retire-to-alloc bypass).
- Wrap: pointers are IDX_W bits and wrap naturally; full/empty are distinguished only by count.
- Flush (synchronous, highest priority):
  - clears all used/completed bits; head=tail=count=0; retire_valid=0
  - alloc, completion and retire in the flush cycle are dropped
- Reset asserted mid-operation behaves exactly as the reset state; no partial retire pulse survives.

Optional Feature:
- ROB_EXCEPTION_EN defined:
  - adds cmpl_exc in NUM_CMPL; each entry stores an exc bit written with completed
  - a completed head entry with exc=1 does not retire; instead it pulses exc_valid (out 1) with exc_pc (out PC_W) = entry pc
  - the ROB then self-flushes on the same edge, identical to flush
- Undefined: no exc storage or ports; exceptions are not tracked.

Decomposition:
- Shared RS/ROB package holds:
  - ROB_ROW_COUNT=64 and field widths
  - a packed typedef rob_entry_t {used, destreg, old_destreg, pc, completed[, exc]}
  - the rob_idx_t typedef, reused by the RS table's rob field
- Natural sub-module: rob_ptr_ctrl (head/tail/count, full/empty, alloc_fire/retire_fire/flush handling). Entry storage and completion logic stay in the top.

Test Plan:
- Reset then 3 allocs (pc 0x100/0x104/0x108) -> alloc_rob_idx 0,1,2; count=3; no retire pulse.
- Complete idx 1, then idx 0 -> no retire after idx 1 alone; after idx 0 completes, retire pulses idx 0 then idx 1 on consecutive cycles with the correct old_destreg; count=1.
- 64 allocs with no completions -> full=1, alloc_ready=0; 65th alloc ignored; tail wraps to 0.
- Full ROB, head completed, alloc_valid held -> retire occurs, alloc refused that cycle; alloc accepted next cycle at idx 0; count stays 64.
- Allocate 10, complete 5, assert flush together with cmpl_valid on idx 7 -> count=0, empty=1, no retire pulse; next alloc gets idx 0.
- With ROB_EXCEPTION_EN: head idx 0 completes with exc=1 -> exc_valid pulse with exc_pc=0x100, no retire_valid, ROB empty next cycle.
